// File: rtl/eth_tx_arb_pkg.sv
// Shared defaults and FSM state encoding for the Ethernet TX requester arbiter.
package eth_tx_arb_pkg;

  localparam int unsigned DefNReq    = 2;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefPktLenW = 16;
  localparam int unsigned DefUdpCsW  = 16;
  localparam int unsigned DefBlockN  = 8;
  localparam int unsigned DefCntW    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StData,
    StGap
  } arb_state_e;

endpackage

// File: rtl/eth_tx_arb_if.sv
// TX-side bus between the arbiter and the eth_tx app_* port.
interface eth_tx_arb_if
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W      = DefPktLenW,
  parameter int unsigned UDP_CS_W       = DefUdpCsW,
  parameter int unsigned BLOCK_N        = DefBlockN,
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
);
  logic                      tx_early_v_o;
  logic [PKT_LEN_W-1:0]      tx_pkt_len_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic [LEN_W-1:0]          tx_len_o;
  logic [UDP_CS_W-1:0]       tx_cs_o;
  logic                      tx_last_o;
  logic                      tx_cancel_o;
  logic                      tx_last_block_next_o;
  logic [APP_LAST_LEN_W-1:0] tx_last_block_next_len_o;
  logic                      tx_ready_v_i;

  modport master (
    output tx_early_v_o, tx_pkt_len_o, tx_data_o, tx_len_o, tx_cs_o, tx_last_o, tx_cancel_o,
    output tx_last_block_next_o, tx_last_block_next_len_o,
    input  tx_ready_v_i
  );

  modport slave (
    input  tx_early_v_o, tx_pkt_len_o, tx_data_o, tx_len_o, tx_cs_o, tx_last_o, tx_cancel_o,
    input  tx_last_block_next_o, tx_last_block_next_len_o,
    output tx_ready_v_i
  );
endinterface

// File: rtl/eth_tx_arb_rr_arb.sv
// Combinational round-robin picker: first request at or after last_i+1 (mod N) wins.
module rr_arb #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    gnt_o
);
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdxW'((32'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arb.sv
// Arbitrates N_REQ application TX requesters onto a single eth_tx app port, one packet at a time.
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = DefNReq,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W      = DefPktLenW,
  parameter int unsigned UDP_CS_W       = DefUdpCsW,
  parameter int unsigned BLOCK_N        = DefBlockN,
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
  parameter int unsigned CNT_W          = DefCntW
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req_early_v_i,
  input  logic [N_REQ*PKT_LEN_W-1:0]        req_pkt_len_i,
  output logic [N_REQ-1:0]                  req_ready_v_o,
  input  logic [N_REQ*DATA_W-1:0]           req_data_i,
  input  logic [N_REQ*LEN_W-1:0]            req_len_i,
  input  logic [N_REQ*UDP_CS_W-1:0]         req_cs_i,
  input  logic [N_REQ-1:0]                  req_last_i,
  input  logic [N_REQ-1:0]                  req_cancel_i,
  input  logic [N_REQ-1:0]                  req_last_block_next_i,
  input  logic [N_REQ*APP_LAST_LEN_W-1:0]   req_last_block_next_len_i,
  eth_tx_arb_if.master                      tx,
  output logic [N_REQ-1:0]                  grant_o,
  output logic                              busy_o,
  output logic [N_REQ*CNT_W-1:0]            pkt_cnt_o
);
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e                   state_q, state_d;
  logic [N_REQ-1:0]             grant_q, grant_d;
  logic [IdxW-1:0]              gidx_q, gidx_d;
  logic [IdxW-1:0]              last_q, last_d;
  logic [PKT_LEN_W-1:0]         pkt_len_q, pkt_len_d;
  logic                         early_q, early_d;
  logic [N_REQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]          arb_gnt;
  logic [IdxW-1:0]           arb_idx;
  logic [PKT_LEN_W-1:0]      arb_pkt_len;
  logic                      sel_last, sel_cancel, sel_lbn, cancel;
  logic [DATA_W-1:0]         sel_data;
  logic [LEN_W-1:0]          sel_len;
  logic [UDP_CS_W-1:0]       sel_cs;
  logic [APP_LAST_LEN_W-1:0] sel_lbn_len;
  logic                      in_data;

  rr_arb #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arb (
    .req_i  (req_early_v_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // One-hot selects; strobes from non-granted requesters are masked out here.
  always_comb begin
    arb_idx     = '0;
    arb_pkt_len = '0;
    sel_data    = '0;
    sel_len     = '0;
    sel_cs      = '0;
    sel_lbn_len = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx     = IdxW'(i);
        arb_pkt_len = req_pkt_len_i[i*PKT_LEN_W +: PKT_LEN_W];
      end
      if (grant_q[i]) begin
        sel_data    = req_data_i[i*DATA_W +: DATA_W];
        sel_len     = req_len_i[i*LEN_W +: LEN_W];
        sel_cs      = req_cs_i[i*UDP_CS_W +: UDP_CS_W];
        sel_lbn_len = req_last_block_next_len_i[i*APP_LAST_LEN_W +: APP_LAST_LEN_W];
      end
    end
    sel_last   = |(req_last_i & grant_q);
    sel_cancel = |(req_cancel_i & grant_q);
    sel_lbn    = |(req_last_block_next_i & grant_q);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    pkt_len_d = pkt_len_q;
    early_d   = early_q;
    cnt_d     = cnt_q;
    cancel    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_early_v_i) begin
          grant_d   = arb_gnt;
          gidx_d    = arb_idx;
          pkt_len_d = arb_pkt_len;
          early_d   = 1'b1;
          state_d   = StHead;
        end
      end
      StHead: begin
        if (sel_cancel) begin
          cancel  = 1'b1;
          early_d = 1'b0;
          grant_d = '0;
          state_d = StGap;
        end else if (tx.tx_ready_v_i) begin
          early_d = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        if (sel_cancel) begin
          cancel  = 1'b1;
          grant_d = '0;
          state_d = StGap;
        end else if (sel_last) begin
          cnt_d[gidx_q] = cnt_q[gidx_q] + CNT_W'(1);
          grant_d       = '0;
          state_d       = StGap;
        end
      end
      StGap: begin
        last_d  = gidx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IdxW'(N_REQ - 1);
      pkt_len_q <= '0;
      early_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      pkt_len_q <= pkt_len_d;
      early_q   <= early_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_data = (state_q == StData);

  always_comb begin
    req_ready_v_o = '0;
    if (state_q == StHead || state_q == StData) begin
      req_ready_v_o = grant_q & {N_REQ{tx.tx_ready_v_i}};
    end
  end

  assign tx.tx_early_v_o             = early_q;
  assign tx.tx_pkt_len_o             = pkt_len_q;
  assign tx.tx_cancel_o              = cancel;
  assign tx.tx_data_o                = in_data ? sel_data : '0;
  assign tx.tx_len_o                 = in_data ? sel_len : '0;
  assign tx.tx_cs_o                  = in_data ? sel_cs : '0;
  assign tx.tx_last_o                = in_data & sel_last;
  assign tx.tx_last_block_next_o     = in_data & sel_lbn;
  assign tx.tx_last_block_next_len_o = in_data ? sel_lbn_len : '0;

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != StIdle);
  assign pkt_cnt_o = cnt_q;
endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomised and directed bench for eth_tx_arb against a packet-level reference model.
module tb_eth_tx_arb;
  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int KW   = DW / 8;
  localparam int LW   = 2;
  localparam int PW   = 16;
  localparam int CSW  = 16;
  localparam int BN   = 8;
  localparam int ALW  = 4;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_early_v_i;
  logic [N*PW-1:0]   req_pkt_len_i;
  logic [N-1:0]      req_ready_v_o;
  logic [N*DW-1:0]   req_data_i;
  logic [N*LW-1:0]   req_len_i;
  logic [N*CSW-1:0]  req_cs_i;
  logic [N-1:0]      req_last_i;
  logic [N-1:0]      req_cancel_i;
  logic [N-1:0]      req_last_block_next_i;
  logic [N*ALW-1:0]  req_last_block_next_len_i;
  logic [N-1:0]      grant_o;
  logic              busy_o;
  logic [N*CNTW-1:0] pkt_cnt_o;

  eth_tx_arb_if #(
    .DATA_W(DW), .KEEP_W(KW), .LEN_W(LW), .PKT_LEN_W(PW), .UDP_CS_W(CSW), .BLOCK_N(BN),
    .APP_LAST_LEN_W(ALW)
  ) tx_if ();

  eth_tx_arb #(
    .N_REQ(N), .DATA_W(DW), .KEEP_W(KW), .LEN_W(LW), .PKT_LEN_W(PW), .UDP_CS_W(CSW),
    .BLOCK_N(BN), .APP_LAST_LEN_W(ALW), .CNT_W(CNTW)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .req_early_v_i             (req_early_v_i),
    .req_pkt_len_i             (req_pkt_len_i),
    .req_ready_v_o             (req_ready_v_o),
    .req_data_i                (req_data_i),
    .req_len_i                 (req_len_i),
    .req_cs_i                  (req_cs_i),
    .req_last_i                (req_last_i),
    .req_cancel_i              (req_cancel_i),
    .req_last_block_next_i     (req_last_block_next_i),
    .req_last_block_next_len_i (req_last_block_next_len_i),
    .tx                        (tx_if),
    .grant_o                   (grant_o),
    .busy_o                    (busy_o),
    .pkt_cnt_o                 (pkt_cnt_o)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Staged stimulus, applied 1 time unit after the next rising edge.
  logic          s_rst;
  logic [N-1:0]  s_early, s_last, s_cancel;
  logic          s_ready;
  logic [PW-1:0] s_len [N];

  // Packet-level reference: who owns the port, whether its header was accepted, gap pending.
  int            m_owner;
  bit            m_headed;
  bit            m_gap;
  int            m_last;
  logic [PW-1:0] m_len;
  logic [15:0]   m_cnt [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_headed = 1'b0;
    m_gap    = 1'b0;
    m_last   = N - 1;
    m_len    = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  // Advance the reference by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && bit_of(req_early_v_i, c)) begin
          m_owner  = c;
          m_headed = 1'b0;
          m_len    = req_pkt_len_i[c*PW +: PW];
        end
      end
    end else if (bit_of(req_cancel_i, m_owner)) begin
      m_last  = m_owner;
      m_owner = -1;
      m_gap   = 1'b1;
    end else if (!m_headed) begin
      if (tx_if.tx_ready_v_i) m_headed = 1'b1;
    end else if (bit_of(req_last_i, m_owner)) begin
      m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
      m_last  = m_owner;
      m_owner = -1;
      m_gap   = 1'b1;
    end
  endtask

  task automatic check_all();
    bit          own, dat;
    logic [63:0] e_grant, e_ready, e_data, e_len, e_cs, e_lbnl, e_cnt;
    bit          e_last, e_lbn, e_cancel;
    own      = (m_owner >= 0);
    dat      = own && m_headed;
    e_grant  = own ? (64'd1 << m_owner) : 64'd0;
    e_ready  = (own && tx_if.tx_ready_v_i) ? e_grant : 64'd0;
    e_data   = 0; e_len = 0; e_cs = 0; e_lbnl = 0;
    e_last   = 1'b0; e_lbn = 1'b0; e_cancel = 1'b0;
    if (own) e_cancel = bit_of(req_cancel_i, m_owner);
    if (dat) begin
      e_data = 64'(req_data_i[m_owner*DW +: DW]);
      e_len  = 64'(req_len_i[m_owner*LW +: LW]);
      e_cs   = 64'(req_cs_i[m_owner*CSW +: CSW]);
      e_lbnl = 64'(req_last_block_next_len_i[m_owner*ALW +: ALW]);
      e_last = bit_of(req_last_i, m_owner);
      e_lbn  = bit_of(req_last_block_next_i, m_owner);
    end
    e_cnt = 0;
    for (int i = 0; i < N; i++) e_cnt = e_cnt | (64'(m_cnt[i]) << (i * CNTW));
    chk("busy", 64'(busy_o), 64'(own || m_gap));
    chk("grant", 64'(grant_o), e_grant);
    chk("tx_early", 64'(tx_if.tx_early_v_o), 64'(own && !m_headed));
    if (own && !m_headed) chk("tx_pkt_len", 64'(tx_if.tx_pkt_len_o), 64'(m_len));
    chk("req_ready", 64'(req_ready_v_o), e_ready);
    chk("tx_data", 64'(tx_if.tx_data_o), e_data);
    chk("tx_len", 64'(tx_if.tx_len_o), e_len);
    chk("tx_cs", 64'(tx_if.tx_cs_o), e_cs);
    chk("tx_last", 64'(tx_if.tx_last_o), 64'(e_last));
    chk("tx_lbn", 64'(tx_if.tx_last_block_next_o), 64'(e_lbn));
    chk("tx_lbn_len", 64'(tx_if.tx_last_block_next_len_o), e_lbnl);
    chk("tx_cancel", 64'(tx_if.tx_cancel_o), 64'(e_cancel));
    chk("pkt_cnt", 64'(pkt_cnt_o), e_cnt);
  endtask

  task automatic apply();
    reset                = s_rst;
    req_early_v_i        = s_early;
    req_last_i           = s_last;
    req_cancel_i         = s_cancel;
    tx_if.tx_ready_v_i   = s_ready;
    req_last_block_next_i = N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_pkt_len_i[i*PW +: PW]               = s_len[i];
      req_data_i[i*DW +: DW]                  = DW'($urandom);
      req_len_i[i*LW +: LW]                   = LW'($urandom_range(0, KW));
      req_cs_i[i*CSW +: CSW]                  = CSW'($urandom);
      req_last_block_next_len_i[i*ALW +: ALW] = ALW'($urandom_range(0, BN + KW));
    end
  endtask

  // One cycle: model follows the edge, new inputs go in, outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1 apply();
    if (reset) model_reset();
    #3 check_all();
  endtask

  task automatic reset_dut();
    s_rst = 1'b1; s_early = '0; s_last = '0; s_cancel = '0; s_ready = 1'b0;
    tick();
    tick();
    s_rst = 1'b0;
    tick();
  endtask

  initial begin
    int beats, ng;
    logic [N-1:0] glog [4];
    s_rst = 1'b1; s_early = '0; s_last = '0; s_cancel = '0; s_ready = 1'b0;
    for (int i = 0; i < N; i++) s_len[i] = '0;
    model_reset();
    apply();

    // Reset state, then a single requester-0 packet of ten beats.
    reset_dut();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_early", 64'(tx_if.tx_early_v_o), 64'd0);
    s_len[0] = 16'd20; s_early = 2'b01;
    tick();
    chk("p1_idle_busy", 64'(busy_o), 64'd0);
    s_early = 2'b00;
    tick();
    chk("p1_grant", 64'(grant_o), 64'd1);
    chk("p1_early", 64'(tx_if.tx_early_v_o), 64'd1);
    chk("p1_len", 64'(tx_if.tx_pkt_len_o), 64'd20);
    tick();
    s_ready = 1'b1;
    tick();
    chk("p1_ready", 64'(req_ready_v_o), 64'd1);
    beats = 0;
    for (int b = 0; b < 10; b++) begin
      s_last = (b == 9) ? 2'b01 : 2'b00;
      tick();
      if (req_ready_v_o[0] && !tx_if.tx_early_v_o) beats++;
    end
    chk("p1_beats", 64'(beats), 64'd10);
    s_last = '0; s_ready = 1'b0;
    tick();
    chk("p1_gap_busy", 64'(busy_o), 64'd1);
    chk("p1_gap_grant", 64'(grant_o), 64'd0);
    chk("p1_cnt", 64'(pkt_cnt_o), 64'h1);
    tick();
    chk("p1_idle_after", 64'(busy_o), 64'd0);

    // Header held fifty cycles without tx ready; requester 1 is next in rotation.
    s_len[1] = 16'h0400; s_early = 2'b10;
    tick();
    s_early = 2'b00;
    tick();
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("hold_early", 64'(tx_if.tx_early_v_o), 64'd1);
      chk("hold_ready", 64'(req_ready_v_o), 64'd0);
      chk("hold_grant", 64'(grant_o), 64'h2);
    end
    s_ready = 1'b1;
    tick();
    s_last = 2'b10;
    tick();
    s_last = '0;
    tick();
    tick();
    chk("hold_cnt", 64'(pkt_cnt_o), 64'h0001_0001);

    // Both requesting continuously: grants alternate starting at 0.
    reset_dut();
    s_early = 2'b11; s_ready = 1'b1; s_last = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (tx_if.tx_early_v_o) begin
        glog[ng] = grant_o;
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 64'd4);
    s_early = 2'b00;
    tick();
    s_last = '0;
    tick();
    tick();
    chk("rr_g0", 64'(glog[0]), 64'h1);
    chk("rr_g1", 64'(glog[1]), 64'h2);
    chk("rr_g2", 64'(glog[2]), 64'h1);
    chk("rr_g3", 64'(glog[3]), 64'h2);
    chk("rr_cnt", 64'(pkt_cnt_o), 64'h0002_0002);

    // Requester 1 strobes last throughout requester 0's packet.
    reset_dut();
    s_early = 2'b01; s_ready = 1'b1; s_last = 2'b10;
    tick();
    s_early = 2'b00;
    tick();
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("foreign_last", 64'(tx_if.tx_last_o), 64'd0);
    end
    s_last = 2'b11;
    tick();
    chk("own_last", 64'(tx_if.tx_last_o), 64'd1);
    s_last = '0;
    tick();
    chk("foreign_cnt", 64'(pkt_cnt_o), 64'h1);
    tick();

    // Cancel and last in the same beat: cancel wins, no count.
    s_early = 2'b01;
    tick();
    s_early = 2'b00;
    tick();
    s_cancel = 2'b01; s_last = 2'b01;
    tick();
    chk("cl_cancel", 64'(tx_if.tx_cancel_o), 64'd1);
    chk("cl_last", 64'(tx_if.tx_last_o), 64'd1);
    s_cancel = '0; s_last = '0;
    tick();
    chk("cl_gap_busy", 64'(busy_o), 64'd1);
    chk("cl_gap_grant", 64'(grant_o), 64'd0);
    chk("cl_cnt", 64'(pkt_cnt_o), 64'h1);
    tick();

    // Reset in the middle of a data phase.
    s_early = 2'b10;
    tick();
    s_early = 2'b00;
    tick();
    tick();
    s_rst = 1'b1;
    tick();
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_grant", 64'(grant_o), 64'd0);
    chk("mr_early", 64'(tx_if.tx_early_v_o), 64'd0);
    chk("mr_cancel", 64'(tx_if.tx_cancel_o), 64'd0);
    chk("mr_data", 64'(tx_if.tx_data_o), 64'd0);
    chk("mr_cnt", 64'(pkt_cnt_o), 64'd0);
    s_rst = 1'b0;
    tick();
    s_early = 2'b11;
    tick();
    s_early = 2'b00;
    tick();
    chk("mr_regrant", 64'(grant_o), 64'h1);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      s_rst    = ($urandom_range(0, 999) == 0);
      s_early  = N'($urandom);
      s_ready  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        s_last[i]   = ($urandom_range(0, 3) == 0);
        s_cancel[i] = ($urandom_range(0, 24) == 0);
        s_len[i]    = PW'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
